// File: rtl/fphub_div_sequencer.sv
// HUB-format floating-point divider (X/Y): special-case bypass plus restoring mantissa divide.
// Define FPHUB_DIV_EARLY_TERM_EN to leave the divide loop as soon as the remainder reaches zero.
module fphub_div_sequencer #(
    parameter int unsigned M            = 23,
    parameter int unsigned E            = 8,
    parameter int unsigned special_case = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] x,
    input  logic [E+M:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] result,
    output logic         out_special,
    output logic         busy
);
    localparam int unsigned W    = E + M + 1;
    localparam int unsigned CW   = $clog2(special_case);
    localparam int unsigned RW   = M + 3;
    localparam int unsigned CntW = $clog2(M + 3);

    localparam logic [CW-1:0]   CodeNone  = CW'(0);
    localparam logic [CW-1:0]   CodeInfP  = CW'(1);
    localparam logic [CW-1:0]   CodeInfN  = CW'(2);
    localparam logic [CW-1:0]   CodeZeroP = CW'(3);
    localparam logic [CW-1:0]   CodeZeroN = CW'(4);
    localparam logic [CW-1:0]   CodeOneP  = CW'(5);
    localparam logic [CW-1:0]   CodeOneN  = CW'(6);
    localparam logic [CntW-1:0] LastIter  = CntW'(M + 2);
    localparam logic [E-1:0]    BiasExp   = {1'b1, {(E-1){1'b0}}};
    localparam logic [E+1:0]    BiasW     = {2'b00, BiasExp};
    localparam logic [E+1:0]    MaxExp    = {2'b00, {E{1'b1}}};

    typedef enum logic [2:0] {StIdle, StSpecial, StDivide, StNorm, StDone} state_e;

    function automatic logic [CW-1:0] classify(input logic [W-1:0] v);
        logic [E-1:0]  ev;
        logic [M-1:0]  fv;
        logic [CW-1:0] code;
        ev = v[E+M-1:M];
        fv = v[M-1:0];
        if (&ev && &fv)                     code = v[E+M] ? CodeInfN : CodeInfP;
        else if (ev == '0 && fv == '0)      code = v[E+M] ? CodeZeroN : CodeZeroP;
        else if (ev == BiasExp && fv == '0) code = v[E+M] ? CodeOneN : CodeOneP;
        else                                code = CodeNone;
        return code;
    endfunction

    function automatic logic is_inf(input logic [CW-1:0] c);
        return (c == CodeInfP) || (c == CodeInfN);
    endfunction

    function automatic logic is_zero(input logic [CW-1:0] c);
        return (c == CodeZeroP) || (c == CodeZeroN);
    endfunction

    function automatic logic is_one(input logic [CW-1:0] c);
        return (c == CodeOneP) || (c == CodeOneN);
    endfunction

    state_e          state_q, state_d;
    logic [W-2:0]    x_mag_q, x_mag_d, y_mag_q, y_mag_d;
    logic [CW-1:0]   x_code_q, x_code_d, y_code_q, y_code_d;
    logic            sign_q, sign_d;
    logic [RW-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    result_q, result_d;
    logic            out_special_q, out_special_d;

    logic [CW-1:0]   x_code_in, y_code_in;
    logic [RW-1:0]   divisor, rem_nxt, quo_nxt;
    logic            rem_ge;
    logic [E+1:0]    exp_w;
    logic [M-1:0]    norm_frac;
    logic [W-1:0]    special_res, norm_res;
    logic            unused_quo_lsb;

    // Quotient LSB falls below the HUB truncation point in both normalisation cases.
    assign unused_quo_lsb = quo_q[0];

    always_comb begin
        x_code_in = classify(x);
        y_code_in = classify(y);

        divisor = {2'b01, y_mag_q[M-1:0], 1'b1};
        rem_ge  = rem_q >= divisor;
        rem_nxt = rem_ge ? rem_q - divisor : rem_q;
        quo_nxt = {quo_q[RW-2:0], rem_ge};

        exp_w     = {2'b00, x_mag_q[E+M-1:M]} - {2'b00, y_mag_q[E+M-1:M]} + BiasW
                  - {{(E+1){1'b0}}, ~quo_q[RW-1]};
        norm_frac = quo_q[RW-1] ? quo_q[M+1:2] : quo_q[M:1];
        if (exp_w[E+1] || exp_w == '0) norm_res = {sign_q, {(W-1){1'b0}}};
        else if (exp_w >= MaxExp)      norm_res = {sign_q, {(W-1){1'b1}}};
        else                           norm_res = {sign_q, exp_w[E-1:0], norm_frac};

        if (is_inf(x_code_q) && is_inf(y_code_q))          special_res = {sign_q, {(W-1){1'b1}}};
        else if (x_code_q == CodeNone && is_inf(y_code_q)) special_res = {sign_q, {(W-1){1'b0}}};
        else if (is_zero(y_code_q))                        special_res = {sign_q, {(W-1){1'b1}}};
        else if (is_zero(x_code_q))                        special_res = {sign_q, {(W-1){1'b0}}};
        else if (is_one(y_code_q))                         special_res = {sign_q, x_mag_q};
        else if (is_inf(x_code_q))                         special_res = {sign_q, {(W-1){1'b1}}};
        else                                               special_res = {sign_q, {(W-1){1'b0}}};
    end

    always_comb begin
        state_d       = state_q;
        x_mag_d       = x_mag_q;
        y_mag_d       = y_mag_q;
        x_code_d      = x_code_q;
        y_code_d      = y_code_q;
        sign_d        = sign_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        result_d      = result_q;
        out_special_d = out_special_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_mag_d  = x[W-2:0];
                    y_mag_d  = y[W-2:0];
                    x_code_d = x_code_in;
                    y_code_d = y_code_in;
                    sign_d   = x[E+M] ^ y[E+M];
                    rem_d    = {2'b01, x[M-1:0], 1'b1};
                    quo_d    = '0;
                    cnt_d    = '0;
                    if (y_code_in != CodeNone || is_inf(x_code_in) || is_zero(x_code_in)) begin
                        state_d = StSpecial;
                    end else begin
                        state_d = StDivide;
                    end
                end
            end
            StSpecial: begin
                result_d      = special_res;
                out_special_d = 1'b1;
                out_valid_d   = 1'b1;
                state_d       = StDone;
            end
            StDivide: begin
                rem_d = rem_nxt << 1;
                quo_d = quo_nxt;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastIter) begin
                    state_d = StNorm;
                end
`ifdef FPHUB_DIV_EARLY_TERM_EN
                else if (rem_nxt == '0) begin
                    // Exact quotient: the remaining bits are all zero.
                    quo_d   = quo_nxt << (LastIter - cnt_q);
                    state_d = StNorm;
                end
`endif
            end
            StNorm: begin
                result_d      = norm_res;
                out_special_d = 1'b0;
                out_valid_d   = 1'b1;
                state_d       = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d   = 1'b0;
                    out_special_d = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            x_mag_q       <= '0;
            y_mag_q       <= '0;
            x_code_q      <= CodeNone;
            y_code_q      <= CodeNone;
            sign_q        <= 1'b0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            out_special_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_mag_q       <= x_mag_d;
            y_mag_q       <= y_mag_d;
            x_code_q      <= x_code_d;
            y_code_q      <= y_code_d;
            sign_q        <= sign_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            out_special_q <= out_special_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign out_special = out_special_q;

endmodule

// File: tb/tb_fphub_div_sequencer.sv
// Self-checking bench for fphub_div_sequencer: directed cases plus random operands vs a value model.
module tb_fphub_div_sequencer;
`ifdef FPHUB_DIV_EARLY_TERM_EN
    localparam int LatEq = 3;
`else
    localparam int LatEq = 28;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        in_ready, out_valid, out_special, busy;
    logic [31:0] result;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fphub_div_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .out_special (out_special),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // 0 ordinary, 1 infinity, 2 zero, 3 one (sign ignored)
    function automatic int cls(input logic [31:0] v);
        if (v[30:0] == 31'h7FFFFFFF) return 1;
        if (v[30:0] == 31'h0)        return 2;
        if (v[30:0] == 31'h40000000) return 3;
        return 0;
    endfunction

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic sp, output int lat);
        int          ca, cb, e, iters, p;
        logic        s;
        logic [63:0] ma, mb, num, q, rm;
        s  = a[31] ^ b[31];
        ca = cls(a);
        cb = cls(b);
        sp = (cb != 0) || (ca == 1) || (ca == 2);
        if (sp) begin
            lat = 2;
            if (ca == 1 && cb == 1)      r = {s, 31'h7FFFFFFF};
            else if (ca == 0 && cb == 1) r = {s, 31'h0};
            else if (cb == 2)            r = {s, 31'h7FFFFFFF};
            else if (ca == 2)            r = {s, 31'h0};
            else if (cb == 3)            r = {s, a[30:0]};
            else if (ca == 1)            r = {s, 31'h7FFFFFFF};
            else                         r = {s, 31'h0};
        end else begin
            // Mantissa value 1.f plus the implicit half-ULP bit, scaled to an integer.
            ma  = (64'd1 << 24) | (64'(a[22:0]) << 1) | 64'd1;
            mb  = (64'd1 << 24) | (64'(b[22:0]) << 1) | 64'd1;
            num = ma << 25;
            q   = num / mb;
            rm  = num % mb;
            e   = int'(a[30:23]) - int'(b[30:23]) + 128;
            if (q >= (64'd1 << 25)) r = {s, 8'h00, q[24:2]};
            else begin
                r = {s, 8'h00, q[23:1]};
                e = e - 1;
            end
            if (e <= 0)        r = {s, 31'h0};
            else if (e >= 255) r = {s, 31'h7FFFFFFF};
            else               r[30:23] = e[7:0];
            iters = 26;
`ifdef FPHUB_DIV_EARLY_TERM_EN
            if (rm == 0) begin
                p = 0;
                for (int i = 0; i < 64; i++) begin
                    if (q[i]) begin
                        p = i;
                        break;
                    end
                end
                iters = 26 - p;
            end
`else
            p = int'(rm[0]);
`endif
            lat = iters + 2;
        end
    endfunction

    function automatic logic [31:0] pick_special();
        logic [31:0] tbl [6];
        tbl = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h40000000, 32'hC0000000};
        return tbl[$urandom_range(0, 5)];
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        x        = a;
        y        = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns n where out_valid is first seen high just before the n-th edge after accept.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle after handshake"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic es, input int el);
        int lat;
        issue(a, b);
        wait_valid(lat);
        chk({tag, " latency"}, lat, el);
        chk({tag, " result"}, result, er);
        chk({tag, " special"}, out_special, es);
        handshake(tag);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        es;
        int          el;
        model(a, b, er, es, el);
        run_dir(tag, a, b, er, es, el);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, held, er;
        logic        es;
        int          lat, el, seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset out_special", out_special, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;

        run_dir("two/one", 32'h40800000, 32'h40000000, 32'h40800000, 1'b1, 2);
        run_dir("one/two", 32'h40000000, 32'h40800000, 32'h3F800000, 1'b0, LatEq);
        run_dir("inf/-inf", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2);
        run_dir("x/zero", 32'h40800000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 2);
        run_dir("-zero/x", 32'h80000000, 32'h40800000, 32'h80000000, 1'b1, 2);
        run_dir("overflow", 32'h7F800000, 32'h00800000, 32'h7FFFFFFF, 1'b0, LatEq);
        run_dir("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, LatEq);
        run_op("model mix", 32'h40123457, 32'hBF654321);

        // Back-pressure with a pending request that must wait for IDLE.
        issue(32'h40000000, 32'h40800000);
        wait_valid(lat);
        chk("bp latency", lat, LatEq);
        held     = result;
        x        = 32'h40C00000;
        y        = 32'h3F800000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp hold", {out_valid, in_ready, held}, {1'b1, 1'b0, 32'h3F800000});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp idle with request", {62'd0, in_ready, out_valid}, 64'd2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        model(32'h40C00000, 32'h3F800000, er, es, el);
        wait_valid(lat);
        chk("bp next latency", lat, el);
        chk("bp next result", result, er);
        handshake("bp next");

        // Reset during divide iteration 10 abandons the operation.
        issue(32'h40123457, 32'h3F654321);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("mid busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid reset state", {busy, in_ready, out_valid, out_special, result},
            {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abandoned silent", seen, 0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b[22:0] = a[22:0];
                1: b = pick_special();
                2: a = pick_special();
                3: begin
                    a[30:23] = 8'($urandom_range(100, 156));
                    b[30:23] = 8'($urandom_range(100, 156));
                end
                default: ;
            endcase
            run_op("random", a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fphub_div_sequencer.md
Name: fphub_div_sequencer

Overview:
Multi-cycle controller and iterative datapath for HUB-format floating-point division (X/Y).
- Accepts one operand pair over a valid/ready handshake and classifies both operands into the team's special-case codes.
- Special results go through the special-result path in one cycle. Normal operands run a restoring mantissa division followed by a normalize/exponent stage.
- Sits between the operand-issue logic and the FP result writeback. Processes one operation at a time.

Parameters:
M, 23, mantissa fraction width (HUB format, implicit leading 1 and implicit trailing ILSB 1)
E, 8, exponent width; bias = 2^(E-1) (+1 encodes as exponent 2^(E-1), fraction 0)
special_case, 7, number of special-case codes including NONE; code width $clog2(special_case)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  high only in IDLE
x  in  E+M+1  dividend {sign, exp, frac}
y  in  E+M+1  divisor
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  downstream accepts result
result  out  E+M+1  quotient, stable while out_valid
out_special  out  1  result came from the special path
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous, active-low; clk is the only clock.
  - On reset: state=IDLE; in_ready=1; out_valid=0; result=0; out_special=0; busy=0; iteration counter=0.
  - Reset asserted mid-operation abandons the operation with no output.
- Classification (combinational on x/y at accept), codes:
  - NONE=0, INF_P=1, INF_N=2, ZERO_P=3, ZERO_N=4, ONE_P=5, ONE_N=6.
  - INF: exp and frac all ones. ZERO: exp and frac all zero. ONE: exp=2^(E-1) and frac=0. Sign selects _P/_N.
- Accept: edge where in_valid && in_ready. x, y, codes and sign = x[E+M]^y[E+M] are registered.
- Path select at accept:
  - Special path when y_code != NONE or x_code in {INF_*, ZERO_*}. Otherwise normal path; this includes x = ONE with y = NONE.
- Special result priority:
  1. x INF and y INF (any signs) -> {sign, all ones}.
  2. x NONE and y INF -> {sign, zero}.
  3. y ZERO -> {sign, all ones}.
  4. x ZERO -> {sign, zero}.
  5. y ONE -> {sign, x[E+M-1:0]}.
  6. Otherwise, with x INF -> {sign, all ones}.
- States: IDLE, SPECIAL, DIVIDE, NORM, DONE.
  - IDLE -> SPECIAL or DIVIDE on accept.
  - SPECIAL -> DONE after 1 cycle.
  - DIVIDE -> NORM after M+3 iterations.
  - NORM -> DONE after 1 cycle.
  - DONE -> IDLE on out_ready.
- Divide datapath:
  - Operand mantissas are {1, frac, 1}, M+2 bits.
  - One quotient bit per cycle, restoring; partial remainder is M+3 bits.
  - Quotient Q is M+3 bits with the integer bit at Q[M+2]; range [0.5, 2).
- NORM stage:
  - If Q[M+2]=1: frac=Q[M+1:2], exp=Ex-Ey+bias.
  - Else: frac=Q[M:1], exp=Ex-Ey+bias-1.
  - Truncation is the HUB round-to-nearest; no rounding adder.
  - Exponent is computed signed on E+2 bits.
  - exp >= 2^E-1 -> {sign, all ones}. exp <= 0 -> {sign, zero}.
- Latency, counted from the accept edge:
  - Special: out_valid high 2 cycles later.
  - Normal: out_valid high M+5 cycles later (28 for M=23).
- Output handshake:
  - out_valid and result hold until out_ready. Back-pressure is unbounded.
  - in_ready stays low until the return to IDLE; no new accept occurs in the same cycle as the result handshake.
- out_special is set with out_valid and cleared on the handshake. result keeps its last value after the handshake.

Optional Feature:
- Macro: FPHUB_DIV_EARLY_TERM_EN.
- Defined: in DIVIDE, if the partial remainder becomes zero after producing a quotient bit, the remaining quotient bits are zero-filled and the block moves to NORM next cycle. Latency varies: X and Y with equal mantissas reach NORM after 1 iteration.
- Undefined: fixed M+3 iterations always. Results are bit-identical in both builds.

Test Plan:
- Reset release, then x=0x40800000 (2.0), y=0x40000000 (+1) -> special path; out_valid 2 cycles after accept; result=0x40800000; out_special=1.
- x=0x40000000, y=0x40800000 -> normal path; result=0x3F800000 (0.5); out_special=0; out_valid exactly 28 cycles after accept without FPHUB_DIV_EARLY_TERM_EN, 3 cycles after accept with it.
- Special-case sweep:
  - x=0x7FFFFFFF (+inf), y=0xFFFFFFFF (-inf) -> 0xFFFFFFFF.
  - x=0x40800000, y=0x00000000 -> 0x7FFFFFFF.
  - x=0x80000000, y=0x40800000 -> 0x80000000.
- Overflow/underflow:
  - x=0x7F800000, y=0x00800000 -> 0x7FFFFFFF.
  - x=0x00800000, y=0x7F000000 -> 0x00000000.
- Back-pressure: hold out_ready=0 for 10 cycles -> out_valid and result stable, in_ready=0, and a new in_valid is not accepted; release -> accepted next operation in the cycle after return to IDLE.
- Reset mid-operation: rst_n low for 1 cycle during DIVIDE iteration 10 -> next cycle state=IDLE, in_ready=1, out_valid=0; the abandoned operation never produces a result.
